write_ptr_full_ctrl: RTL and testbench
======================================

WRITE_PTR_FULL_CTRL -- requirements
Module: write_ptr_full_ctrl

Interface
REQ-001 SHALL have parameter PTR_WIDTH, default 4, meaning FIFO address width (depth = 2**PTR_WIDTH).
REQ-002 SHALL have parameter AFULL_THRESH, default 12, meaning occupancy at or above which walmost_full asserts (legal range 1..2**PTR_WIDTH).
REQ-003 SHALL run on one clock and an asynchronous active-low reset; port list as follows.
REQ-004 wclk  input  1  write-domain clock, all state on rising edge.
REQ-005 wrst_n  input  1  asynchronous active-low reset.
REQ-006 winc  input  1  write request for the current cycle.
REQ-007 rptr_gray_sync  input  PTR_WIDTH+1  read pointer (Gray), already synchronized into wclk.
REQ-008 wovf_clr  input  1  clears the sticky overflow flag.
REQ-009 waddr  output  PTR_WIDTH  RAM write address.
REQ-010 wptr_gray  output  PTR_WIDTH+1  registered write pointer (Gray), to be sent to the read domain.
REQ-011 wfull  output  1  FIFO full, registered.
REQ-012 walmost_full  output  1  occupancy >= AFULL_THRESH, registered.
REQ-013 wlevel  output  PTR_WIDTH+1  conservative occupancy (0..2**PTR_WIDTH), registered.
REQ-014 wovf  output  1  sticky overflow flag.

Function
REQ-015 SHALL hold a binary write pointer wbin of PTR_WIDTH+1 bits; waddr = wbin[PTR_WIDTH-1:0].
REQ-016 SHALL accept a write when winc=1 and wfull=0; wbin_next = wbin + accept, wrapping modulo 2**(PTR_WIDTH+1).
REQ-017 SHALL register wptr_gray = wbin_next ^ (wbin_next >> 1), so exactly one bit changes per accepted write.
REQ-018 SHALL compute wfull_next = (gray(wbin_next) == {~rptr_gray_sync[PTR_WIDTH:PTR_WIDTH-1], rptr_gray_sync[PTR_WIDTH-2:0]}) and register it.
REQ-019 SHALL convert rptr_gray_sync to binary (XOR prefix from MSB) and register wlevel = (wbin_next - rbin) mod 2**(PTR_WIDTH+1).
REQ-020 SHALL register walmost_full = (wlevel_next >= AFULL_THRESH).
REQ-021 Latency: write accepted in cycle N -> waddr, wptr_gray, wfull, wlevel, walmost_full reflect it after edge N+1; full asserts on the same edge as the write that fills the last slot.
REQ-022 A change of rptr_gray_sync SHALL update wfull/wlevel/walmost_full at the next edge (no extra pipeline stage).
REQ-023 winc=1 while wfull=1 SHALL NOT change wbin/wptr_gray and SHALL set wovf at the next edge.
REQ-024 wovf SHALL stay set until a cycle with wovf_clr=1 and no new overflow; simultaneous overflow and wovf_clr SHALL leave wovf=1.
REQ-025 Write while a read frees a slot in the same cycle: the write is judged against registered wfull; level SHALL equal wbin_next minus the new rbin.
REQ-026 Pointer wrap (wbin 2**(PTR_WIDTH+1)-1 -> 0) SHALL be seamless; full/level arithmetic unaffected.

Reset
REQ-027 wrst_n=0 SHALL asynchronously force wbin=0, wptr_gray=0, waddr=0, wfull=0, walmost_full=0, wlevel=0, wovf=0.
REQ-028 Reset asserted mid-operation SHALL discard state immediately; winc is ignored while wrst_n=0; first accept possible on the first edge after release.

Verification
REQ-029 Reset, rptr_gray_sync=0, 16 consecutive winc -> wptr_gray sequence 1,3,2,6,...; wfull=1 and wlevel=16 after the 16th edge; walmost_full=1 after the 12th.
REQ-030 Full, 3 more winc -> wptr_gray unchanged at 5'b11000, wovf=1; wovf_clr pulse -> wovf=0 next edge.
REQ-031 Full, rptr_gray_sync stepped to gray(1)=5'b00001 -> wfull=0, wlevel=15 next edge; one winc -> wfull=1 again.
REQ-032 Run 40 writes against a read pointer tracking 2 cycles behind -> wptr_gray wraps past 31 to 0, only one bit changes per step, wfull never set.
REQ-033 Assert wrst_n=0 mid-clock with wlevel=7, wovf=1 -> all outputs 0 immediately, before the next edge.
REQ-034 winc=1 and wovf_clr=1 in the same cycle while full -> wovf remains 1.

Source files
------------

// File: rtl/write_ptr_full_ctrl.sv
// Write-side pointer/full controller for an async FIFO: binary+Gray write pointer, full, almost-full, level, sticky overflow.
// Latency: every output is registered and reflects an accepted write or a read-pointer change after the next wclk edge.
// Backpressure: a write is accepted only while registered wfull is low; a write attempted while full is dropped and sets wovf.
module write_ptr_full_ctrl #(
    parameter int PTR_WIDTH    = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    input  logic                 winc,
    input  logic [PTR_WIDTH:0]   rptr_gray_sync,
    input  logic                 wovf_clr,
    output logic [PTR_WIDTH-1:0] waddr,
    output logic [PTR_WIDTH:0]   wptr_gray,
    output logic                 wfull,
    output logic                 walmost_full,
    output logic [PTR_WIDTH:0]   wlevel,
    output logic                 wovf
);

    localparam logic [PTR_WIDTH+1:0] AFULL_T = (PTR_WIDTH+2)'(AFULL_THRESH);

    function automatic logic [PTR_WIDTH:0] gray2bin(input logic [PTR_WIDTH:0] g);
        logic [PTR_WIDTH:0] b;
        b[PTR_WIDTH] = g[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PTR_WIDTH:0] wbin;
    logic [PTR_WIDTH:0] wbin_next;
    logic [PTR_WIDTH:0] wgray_next;
    logic [PTR_WIDTH:0] rbin;
    logic [PTR_WIDTH:0] rgray_full;
    logic [PTR_WIDTH:0] wlevel_next;
    logic               accept;
    logic               overflow;
    logic               wfull_next;
    logic               walmost_full_next;
    logic               wovf_next;

    always_comb begin
        accept            = winc & ~wfull;
        overflow          = winc & wfull;
        wbin_next         = wbin + {{PTR_WIDTH{1'b0}}, accept};
        wgray_next        = wbin_next ^ (wbin_next >> 1);
        rbin              = gray2bin(rptr_gray_sync);
        // Full when write pointer is one lap ahead: top two Gray bits inverted, rest equal.
        rgray_full        = {~rptr_gray_sync[PTR_WIDTH:PTR_WIDTH-1], rptr_gray_sync[PTR_WIDTH-2:0]};
        wfull_next        = (wgray_next == rgray_full);
        wlevel_next       = wbin_next - rbin;
        walmost_full_next = ({1'b0, wlevel_next} >= AFULL_T);
        // A fresh overflow outranks a same-cycle clear.
        wovf_next         = overflow | (wovf & ~wovf_clr);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin         <= '0;
            wptr_gray    <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            wovf         <= 1'b0;
        end else begin
            wbin         <= wbin_next;
            wptr_gray    <= wgray_next;
            wfull        <= wfull_next;
            walmost_full <= walmost_full_next;
            wlevel       <= wlevel_next;
            wovf         <= wovf_next;
        end
    end

    assign waddr = wbin[PTR_WIDTH-1:0];

endmodule

// File: tb/tb_write_ptr_full_ctrl.sv
// Directed bench for write_ptr_full_ctrl (PTR_WIDTH=4, AFULL_THRESH=12): vector table plus wrap and mid-cycle reset sequences.
module tb_write_ptr_full_ctrl;

    logic       wclk = 1'b0;
    logic       wrst_n;
    logic       winc;
    logic [4:0] rptr_gray_sync;
    logic       wovf_clr;
    logic [3:0] waddr;
    logic [4:0] wptr_gray;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
    logic       wovf;

    int n_cmp  = 0;
    int n_fail = 0;

    write_ptr_full_ctrl #(
        .PTR_WIDTH    (4),
        .AFULL_THRESH (12)
    ) dut (
        .wclk           (wclk),
        .wrst_n         (wrst_n),
        .winc           (winc),
        .rptr_gray_sync (rptr_gray_sync),
        .wovf_clr       (wovf_clr),
        .waddr          (waddr),
        .wptr_gray      (wptr_gray),
        .wfull          (wfull),
        .walmost_full   (walmost_full),
        .wlevel         (wlevel),
        .wovf           (wovf)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic       winc;
        logic [4:0] rg;
        logic       clr;
        logic [3:0] waddr;
        logic [4:0] gray;
        logic       full;
        logic       afull;
        logic [4:0] level;
        logic       ovf;
    } vec_t;

    vec_t vt[$];

    logic [4:0] gseq [16] = '{5'd1, 5'd3, 5'd2, 5'd6, 5'd7, 5'd5, 5'd4, 5'd12,
                              5'd13, 5'd15, 5'd14, 5'd10, 5'd11, 5'd9, 5'd8, 5'd24};

    function automatic vec_t mk(input logic wi, input logic [4:0] rg, input logic clr,
                                input logic [3:0] wa, input logic [4:0] gr, input logic fu,
                                input logic af, input logic [4:0] lv, input logic ov);
        vec_t v;
        v.winc = wi; v.rg = rg; v.clr = clr; v.waddr = wa; v.gray = gr;
        v.full = fu; v.afull = af; v.level = lv; v.ovf = ov;
        return v;
    endfunction

    function automatic logic [4:0] g(input int x);
        logic [4:0] b;
        b = 5'(x);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic wi, input logic [4:0] rg, input logic clr);
        winc = wi;
        rptr_gray_sync = rg;
        wovf_clr = clr;
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        wrst_n = 1'b0;
        winc = 1'b0;
        wovf_clr = 1'b0;
        rptr_gray_sync = '0;
        @(posedge wclk);
        @(negedge wclk);
        wrst_n = 1'b1;
        #4;
    endtask

    initial begin
        // Vector table: fill, overflow, clear, read frees slot, refill, overflow+clear race, write during read.
        for (int k = 0; k < 16; k++)
            vt.push_back(mk(1'b1, 5'd0, 1'b0, 4'((k + 1) % 16), gseq[k], k == 15, (k + 1) >= 12, 5'(k + 1), 1'b0));
        for (int k = 0; k < 3; k++)
            vt.push_back(mk(1'b1, 5'd0, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1));
        vt.push_back(mk(1'b0, 5'd0,      1'b1, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b0));
        vt.push_back(mk(1'b0, 5'b00001, 1'b0, 4'd0, 5'b11000, 1'b0, 1'b1, 5'd15, 1'b0));
        vt.push_back(mk(1'b1, 5'b00001, 1'b0, 4'd1, 5'b11001, 1'b1, 1'b1, 5'd16, 1'b0));
        vt.push_back(mk(1'b1, 5'b00001, 1'b1, 4'd1, 5'b11001, 1'b1, 1'b1, 5'd16, 1'b1));
        vt.push_back(mk(1'b0, 5'b00001, 1'b1, 4'd1, 5'b11001, 1'b1, 1'b1, 5'd16, 1'b0));
        vt.push_back(mk(1'b0, 5'b00011, 1'b0, 4'd1, 5'b11001, 1'b0, 1'b1, 5'd15, 1'b0));
        vt.push_back(mk(1'b1, 5'b00010, 1'b0, 4'd2, 5'b11011, 1'b0, 1'b1, 5'd15, 1'b0));

        // Reset state, with winc held high while in reset.
        wrst_n = 1'b0;
        winc = 1'b1;
        wovf_clr = 1'b0;
        rptr_gray_sync = '0;
        #1;
        chk("rst gray", 32'(wptr_gray), 0);
        chk("rst level", 32'(wlevel), 0);
        @(posedge wclk);
        #1;
        chk("rst winc ignored gray", 32'(wptr_gray), 0);
        chk("rst flags", {wfull, walmost_full, wovf, waddr}, 0);
        @(negedge wclk);
        wrst_n = 1'b1;
        winc = 1'b0;
        #4;

        foreach (vt[i]) begin
            step(vt[i].winc, vt[i].rg, vt[i].clr);
            chk($sformatf("vec%0d waddr", i), 32'(waddr), 32'(vt[i].waddr));
            chk($sformatf("vec%0d gray", i), 32'(wptr_gray), 32'(vt[i].gray));
            chk($sformatf("vec%0d full", i), 32'(wfull), 32'(vt[i].full));
            chk($sformatf("vec%0d afull", i), 32'(walmost_full), 32'(vt[i].afull));
            chk($sformatf("vec%0d level", i), 32'(wlevel), 32'(vt[i].level));
            chk($sformatf("vec%0d ovf", i), 32'(wovf), 32'(vt[i].ovf));
        end

        // 40 writes against a read pointer trailing by two, across the pointer wrap.
        do_reset();
        begin
            logic [4:0] prev;
            prev = 5'd0;
            for (int i = 1; i <= 40; i++) begin
                int rb;
                rb = (i > 3) ? i - 3 : 0;
                step(1'b1, g(rb), 1'b0);
                chk($sformatf("wrap%0d gray", i), 32'(wptr_gray), 32'(g(i)));
                chk($sformatf("wrap%0d onebit", i), $countones(wptr_gray ^ prev), 1);
                chk($sformatf("wrap%0d full", i), 32'(wfull), 0);
                chk($sformatf("wrap%0d level", i), 32'(wlevel), i - rb);
                prev = wptr_gray;
            end
            chk("wrap end gray", 32'(wptr_gray), 32'(5'b01100));
        end

        // Build level 7 with overflow set, then reset mid-cycle.
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 5'd0, 1'b0);
        step(1'b1, 5'd0, 1'b0);
        step(1'b0, 5'b01101, 1'b0);
        chk("pre-rst level", 32'(wlevel), 7);
        chk("pre-rst ovf", 32'(wovf), 1);
        chk("pre-rst full", 32'(wfull), 0);
        chk("pre-rst afull", 32'(walmost_full), 0);
        #3;
        wrst_n = 1'b0;
        winc = 1'b1;
        #1;
        chk("async rst level", 32'(wlevel), 0);
        chk("async rst ovf", 32'(wovf), 0);
        chk("async rst gray", 32'(wptr_gray), 0);
        chk("async rst misc", {wfull, walmost_full, waddr}, 0);
        rptr_gray_sync = '0;
        @(posedge wclk);
        #1;
        chk("held rst gray", 32'(wptr_gray), 0);
        @(negedge wclk);
        wrst_n = 1'b1;
        @(posedge wclk);
        #1;
        chk("post rst gray", 32'(wptr_gray), 1);
        chk("post rst waddr", 32'(waddr), 1);
        chk("post rst level", 32'(wlevel), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
